serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial adder: the inverse operation of the 4-bit subtractor. Computes A + B over WIDTH
//   clock cycles, one bit per cycle, LSB first, and returns Sum and Carry.
//   Carry is the counterpart of Borrow. Sits beside the subtractor in the arithmetic block.
//   Also serves as its round-trip checker: Diff + B must reproduce A.
//   Uses a start/busy/done handshake so a sequencer can issue operations.
// PARAMETERS
//   WIDTH   4   operand/result width in bits; legal range WIDTH >= 1
// PORTS
//   clk     input   1      rising-edge clock
//   rst     input   1      asynchronous, active-high reset
//   start   input   1      request; sampled only in IDLE
//   A       input   WIDTH  augend, latched on accepted start
//   B       input   WIDTH  addend, latched on accepted start
//   busy    output  1      high while an operation is in progress (state ADD)
//   done    output  1      one-cycle pulse; Sum/Carry valid from this cycle
//   Sum     output  WIDTH  (A + B) mod 2^WIDTH, registered
//   Carry   output  1      carry out of bit WIDTH-1, registered
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, Sum=0, Carry=0, busy=0, done=0. Internal shift regs,
//     carry flop and bit counter are cleared. An in-flight operation is discarded; no done.
//   FSM states: IDLE -> ADD -> DONE -> IDLE.
//   IDLE
//     - start=1 at edge t0: latch A,B into shift regs, carry flop=0, counter=0, go to ADD.
//     - start=0: stay in IDLE.
//   ADD
//     - Each edge computes s = a[0]^b[0]^c and c' = maj(a[0],b[0],c).
//     - s shifts into the MSB of the internal result reg; operand regs shift right; counter++.
//     - Edges t0+1 .. t0+WIDTH process bits 0 .. WIDTH-1.
//     - At edge t0+WIDTH: Sum <= result, Carry <= c', go to DONE.
//   DONE
//     - done=1 for exactly one cycle (after edge t0+WIDTH).
//     - Unconditional return to IDLE at the next edge; done returns to 0.
//   Timing
//     - Latency: done is visible WIDTH edges after the accepting edge.
//     - Throughput: one operation per WIDTH+2 cycles.
//   Output stability
//     - Sum/Carry update only on the ADD->DONE transition.
//     - They hold their value through IDLE and the next ADD until the next result.
//   Ignored inputs
//     - start is ignored in ADD and DONE; it is neither queued nor an error.
//     - A and B are ignored except on the accepting edge; changes mid-operation have no effect.
//   Width rules
//     - Sum is truncated to WIDTH bits.
//     - Carry=1 iff A+B >= 2^WIDTH.
//     - Counter is $clog2(WIDTH)+1 bits, so WIDTH=1 works: exactly one ADD cycle.
//   Outputs are fully registered; there is no combinational path from inputs to outputs.
// TESTING (WIDTH=4)
//   1. Basic add: A=9, B=3, start pulse.
//      -> busy=1 for 4 cycles; done pulse 4 edges after the accepting edge; Sum=12, Carry=0.
//   2. Overflow and wrap: 15+15 -> Sum=14, Carry=1; 15+1 -> Sum=0, Carry=1; 0+0 -> Sum=0, Carry=0.
//   3. Ignored inputs: start held high throughout; A/B changed every cycle while busy.
//      -> result uses the latched operands; exactly one done per accepted start.
//      -> next accept no earlier than 2 edges after done.
//   4. Reset mid-ADD: assert rst after 2 ADD cycles.
//      -> immediately Sum=0, Carry=0, busy=0, done=0, and no done afterward.
//      -> a following start with A=7, B=5 gives Sum=12, Carry=0.
//   5. Output hold: after 4+2=6, start 1+1.
//      -> Sum stays 6 during that ADD phase, then becomes 2 at its done.
//   6. Exhaustive round-trip: all 256 (A,B) pairs.
//      -> Sum == (A+B)&15 and Carry == (A+B>15).
//      -> feeding Sum and B to Subtractor_4bit gives Diff == A, with Borrow == Carry.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a sequencer and the bit-serial adder.
// The sequencer drives start/A/B; the adder returns busy/done/Sum/Carry.
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Carry;

    modport master (
        output start, A, B,
        input  busy, done, Sum, Carry
    );

    modport slave (
        input  start, A, B,
        output busy, done, Sum, Carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock; companion and round-trip checker
// for the subtractor. Sum/Carry are registered and only change when a result completes.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);
    // One extra counter bit keeps WIDTH=1 legal and lets the counter reach WIDTH-1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        s       = a_sr[0] ^ b_sr[0] ^ c;
        c_nxt   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
        // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_nxt = res >> 1;
        res_nxt[WIDTH-1] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res       <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.Sum   <= '0;
            bus.Carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.A;
                        b_sr     <= bus.B;
                        res      <= '0;
                        c        <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= res_nxt;
                    c    <= c_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.Sum   <= res_nxt;
                        bus.Carry <= c_nxt;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): latency, wrap/carry, ignored inputs,
// async reset mid-operation, output hold, and an exhaustive add/subtract round trip.
module tb_serial_adder;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] last_sum = '0;
    logic       last_carry = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full operation; A/B are scrambled while busy and Sum/Carry must hold the previous result.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] es, input logic ec);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            check("busy_in_add", {31'd0, bus.busy}, 32'd1);
            check("hold_sum", {28'd0, bus.Sum}, {28'd0, last_sum});
            check("hold_carry", {31'd0, bus.Carry}, {31'd0, last_carry});
            bus.A = bus.A + 4'd3; bus.B = ~bus.B;
            @(negedge clk);
            n++;
        end
        check("latency", n, W);
        check("sum", {28'd0, bus.Sum}, {28'd0, es});
        check("carry", {31'd0, bus.Carry}, {31'd0, ec});
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        last_sum = es; last_carry = ec;
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        logic [4:0] full;
        logic [3:0] diff, s_dut;
        logic borrow;

        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_sum", {28'd0, bus.Sum}, 32'd0);
        check("rst_carry", {31'd0, bus.Carry}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // basic add and wrap cases
        run_op(4'd9, 4'd3, 4'd12, 1'b0);
        run_op(4'd15, 4'd1, 4'd0, 1'b1);
        run_op(4'd0, 4'd0, 4'd0, 1'b0);
        run_op(4'd15, 4'd15, 4'd14, 1'b1);

        // start held high, operands changing every cycle
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd6;
        @(negedge clk);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) ndone++;
            if (i == 4) begin
                check("held_start_done1", {31'd0, bus.done}, 32'd1);
                check("held_start_sum1", {28'd0, bus.Sum}, 32'd11);
            end
            if (i == 5) check("no_accept_1_after_done", {31'd0, bus.busy}, 32'd0);
            if (i == 6) check("accept_2_after_done", {31'd0, bus.busy}, 32'd1);
            if (i == 10) begin
                check("held_start_done2", {31'd0, bus.done}, 32'd1);
                check("held_start_sum2", {28'd0, bus.Sum}, 32'd5);
            end
            if (i == 5) begin
                bus.A = 4'd2; bus.B = 4'd3;
            end else begin
                bus.A = 4'($urandom); bus.B = 4'($urandom);
            end
            if (i == 6) bus.start = 1'b0;
            @(negedge clk);
        end
        check("held_start_done_count", ndone, 2);
        last_sum = 4'd5; last_carry = 1'b0;

        // reset after two ADD cycles, with a nonzero result in place
        run_op(4'd15, 4'd15, 4'd14, 1'b1);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd3; bus.B = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_sum", {28'd0, bus.Sum}, 32'd0);
        check("midrst_carry", {31'd0, bus.Carry}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        last_sum = '0; last_carry = 1'b0;
        run_op(4'd7, 4'd5, 4'd12, 1'b0);

        // output hold: 6 must persist through the next ADD phase
        run_op(4'd4, 4'd2, 4'd6, 1'b0);
        run_op(4'd1, 4'd1, 4'd2, 1'b0);

        // exhaustive round trip through a subtractor model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                full = 5'(a) + 5'(b);
                run_op(4'(a), 4'(b), full[3:0], full[4]);
                s_dut  = bus.Sum;
                diff   = s_dut - 4'(b);
                borrow = (s_dut < 4'(b));
                check("rt_diff", {28'd0, diff}, a);
                check("rt_borrow", {31'd0, borrow}, {31'd0, bus.Carry});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
